ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It consumes the two resolved operands that ID forwards through the ID/EX register (rs in oprd1, rt in oprd2) for MULT/MULTU/DIV/DIVU. It computes a 64-bit result over multiple cycles, holds the pipeline through `stallreq_from_ex` while working, and owns the architectural HI/LO registers. ID and EX read HI/LO from here for MFHI/MFLO; MTHI/MTLO write them here.

## Interface
- `DATA_W`, 32: operand and HI/LO width; the iteration count equals DATA_W.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  a mul/div instruction is valid in EX this cycle.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only on an accepted start.
- `oprd1`  in  DATA_W  rs value (multiplicand / dividend).
- `oprd2`  in  DATA_W  rt value (multiplier / divisor).
- `flush`  in  1  cancel any in-flight operation; no HI/LO update.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  DATA_W  MTHI/MTLO data.
- `stallreq_from_ex`  out  1  pipeline hold request.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi_o`, `lo_o`  out  DATA_W  current HI/LO register values.

## Operation
- States: IDLE, CALC, FIN.
- IDLE, start=1, flush=0:
  - latch |oprd1| and |oprd2| (absolute value only for signed ops; 0x80000000 stays 0x80000000 as an unsigned magnitude);
  - latch sign flags s1/s2 and op; clear the 6-bit counter.
  - Next state: CALC, or FIN when op is DIV/DIVU and oprd2==0.
- CALC, one radix-2 step per cycle:
  - multiply: shift-add into a 64-bit accumulator;
  - divide: restoring shift-subtract into a 64-bit {rem, quot} register.
  - Counter increments each cycle; after DATA_W steps (counter==DATA_W-1 in the current cycle), go to FIN.
- FIN:
  - sign-correct the result: MULT negates the 64-bit product if s1^s2; DIV negates the quotient if s1^s2 and the remainder if s1.
  - Write HI={product[63:32] | remainder} and LO={product[31:0] | quotient}.
  - Pulse done; return to IDLE.
- Divide by zero: FIN is entered with no calc; done pulses; HI/LO keep their old values.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000 and HI=0 (two's-complement wrap); no trap.
- flush in CALC or FIN: next state IDLE, no HI/LO write, no done. flush in IDLE blocks acceptance of start in the same cycle.
- start while busy is ignored. The stall guarantees it is the same instruction held in EX.
- hi_we/lo_we update HI/LO at the clock edge only when the state is IDLE, or in FIN under flush. In a normal FIN cycle the computed result wins and the MTHI/MTLO write is dropped.
- All arithmetic is unsigned on magnitudes; sign correction is done only in FIN.

## Timing
- Reset (rst=1 at a clock edge): state IDLE, HI=0, LO=0, counter=0, done=0, busy=0, stallreq_from_ex=0. This applies mid-operation too, and the in-flight result is discarded.
- `stallreq_from_ex` is combinational: 1 when (state==IDLE and start and !flush) or state==CALC. It is 0 in FIN so the instruction leaves EX on the edge that ends FIN.
- Start accepted at the edge ending cycle T:
  - CALC covers cycles T+1..T+32;
  - FIN is cycle T+33, with done=1;
  - HI/LO show the new value in cycle T+34. Total stall is 33 cycles.
- Divide by zero: FIN is cycle T+1 and stall lasts 1 cycle.
- `busy` is registered-state-derived, with no combinational path from inputs.
- MFHI/MFLO forwarding of a result in flight is unnecessary. The stall prevents a younger instruction from reaching EX before the FIN edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> done at T+33; HI=0xFFFFFFFE, LO=0x00000001; stallreq high for exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=0x0000000E, HI=0x00000002. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU by 0 with HI=0x11111111, LO=0x22222222 preloaded via MTHI/MTLO -> done at T+1, HI/LO unchanged, stall 1 cycle.
- MULTU 7×9 with flush at T+10 -> IDLE at T+11, no done, HI/LO unchanged. Then a new start is accepted normally.
- rst asserted at T+20 of a DIVU -> HI=LO=0 and busy=0 next cycle. Also: hi_we with wdata=0xABCD0000 during FIN of a MULTU 2×3 -> HI=0, LO=6, and the MTHI write is dropped.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage.
// Computes MULT/MULTU/DIV/DIVU over DATA_W radix-2 steps on operand
// magnitudes, sign-corrects in FIN, and owns the HI/LO registers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op           accept a mul/div (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//   oprd1, oprd2        rs / rt operands
//   flush               cancel in-flight op, no HI/LO update
//   hi_we, lo_we, wdata MTHI/MTLO writes
//   stallreq_from_ex    pipeline hold request (combinational)
//   busy                state is not IDLE
//   done                one-cycle pulse in an unflushed FIN
//   hi_o, lo_o          current HI/LO values
module ex_muldiv #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] oprd1,
  input  logic [DATA_W-1:0] oprd2,
  input  logic              flush,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              stallreq_from_ex,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic [DATA_W-1:0]     mag_q, mag_d;   // multiplicand (mul) or divisor (div)
  logic [2*DATA_W-1:0]   acc_q, acc_d;   // product, or {rem, quot}
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;

  logic                  neg1, neg2;
  logic [DATA_W-1:0]     abs1, abs2;
  logic [DATA_W:0]       msum;
  logic [DATA_W:0]       dshift, ddiff;
  logic [2*DATA_W-1:0]   mstep, dstep;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix, rem_fix;
  logic [DATA_W-1:0]     fin_hi, fin_lo;
  logic                  div0;

  // Magnitudes: only signed ops take the absolute value; the most negative
  // value negates to itself and is then read as an unsigned magnitude.
  assign neg1 = ~op[0] & oprd1[DATA_W-1];
  assign neg2 = ~op[0] & oprd2[DATA_W-1];
  assign abs1 = neg1 ? -oprd1 : oprd1;
  assign abs2 = neg2 ? -oprd2 : oprd2;

  // Multiply step: add multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right.
  assign msum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
               + (acc_q[0] ? {1'b0, mag_q} : {(DATA_W+1){1'b0}});
  assign mstep = {msum, acc_q[DATA_W-1:1]};

  // Restoring divide step. Since rem < divisor, the shifted remainder is
  // below 2*divisor, so ddiff's top bit is set exactly when it borrowed.
  assign dshift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign ddiff  = dshift - {1'b0, mag_q};
  assign dstep  = ddiff[DATA_W]
                ? {dshift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                : {ddiff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};

  assign prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
  assign quot_fix = (s1_q ^ s2_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = s1_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  assign fin_hi   = op_q[1] ? rem_fix  : prod_fix[2*DATA_W-1:DATA_W];
  assign fin_lo   = op_q[1] ? quot_fix : prod_fix[DATA_W-1:0];
  assign div0     = op_q[1] && (mag_q == '0);

  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    s1_d             = s1_q;
    s2_d             = s2_q;
    mag_d            = mag_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    hi_d             = hi_q;
    lo_d             = lo_q;
    stallreq_from_ex = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          stallreq_from_ex = 1'b1;
          op_d  = op;
          s1_d  = neg1;
          s2_d  = neg2;
          cnt_d = '0;
          if (op[1]) begin
            mag_d   = abs2;
            acc_d   = {{DATA_W{1'b0}}, abs1};
            state_d = (oprd2 == '0) ? S_FIN : S_CALC;
          end else begin
            mag_d   = abs1;
            acc_d   = {{DATA_W{1'b0}}, abs2};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        stallreq_from_ex = 1'b1;
        cnt_d = cnt_q + 1'b1;
        acc_d = op_q[1] ? dstep : mstep;
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_STEP) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          done = 1'b1;
          if (!div0) begin
            hi_d = fin_hi;
            lo_d = fin_lo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // MTHI/MTLO only land when no result is being committed this cycle.
    if ((state_q == S_IDLE) || ((state_q == S_FIN) && flush)) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an
// arithmetic reference model (64-bit integer multiply/divide).
module tb_ex_muldiv;

  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] oprd1;
  logic [DATA_W-1:0] oprd2;
  logic              flush;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              stallreq_from_ex;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  ex_muldiv #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .oprd1(oprd1), .oprd2(oprd2), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .stallreq_from_ex(stallreq_from_ex), .busy(busy), .done(done),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enter the next cycle: 1 time unit after the rising edge, inputs idle.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output bit dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0; eh = '0; el = '0;
    case (o)
      2'd0: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (b == 0) dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); el = p[31:0];
          p = 64'(r); eh = p[31:0];
        end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  task automatic mt_write(input bit is_hi, input logic [31:0] d);
    tick();
    hi_we = is_hi; lo_we = !is_hi; wdata = d;
    if (is_hi) hi_m = d; else lo_m = d;
    #1;
  endtask

  // Run one mul/div. fl >= 0 asserts flush in cycle fl (cycle 0 = accept).
  // mt asserts hi_we in the FIN cycle; that write must be dropped.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int fl, input bit mt);
    logic [31:0] eh, el;
    bit dz;
    int lat, last, stalls, done_cnt, done_at;
    ref_model(o, a, b, eh, el, dz);
    lat = dz ? 1 : DATA_W + 1;
    last = (fl >= 0) ? fl + 2 : lat + 1;
    stalls = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k <= last; k++) begin
      tick();
      start = (k < lat) && (fl < 0 || k <= fl);
      op = o; oprd1 = a; oprd2 = b;
      flush = (k == fl);
      hi_we = mt && (k == lat);
      wdata = 32'hABCD0000;
      #1;
      if (stallreq_from_ex) stalls++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (fl >= 0 && k == fl + 1) check("busy_after_flush", 64'(busy), 64'(0));
    end
    if (fl < 0) begin
      if (!dz) begin hi_m = eh; lo_m = el; end
      check("done_cycle", 64'(done_at), 64'(lat));
      check("done_count", 64'(done_cnt), 64'(1));
      check("stall_cycles", 64'(stalls), 64'(lat));
    end else begin
      check("done_count_flushed", 64'(done_cnt), 64'(0));
      check("stall_cycles_flushed", 64'(stalls), 64'(fl + 1));
    end
    check("busy_end", 64'(busy), 64'(0));
    check("hi", 64'(hi_o), 64'(hi_m));
    check("lo", 64'(lo_o), 64'(lo_m));
  endtask

  initial begin
    logic [31:0] corners [6];
    logic [1:0] ro;
    logic [31:0] ra, rb;
    int rfl;
    bit rmt;
    corners[0] = 32'h80000000; corners[1] = 32'hFFFFFFFF; corners[2] = 32'h0;
    corners[3] = 32'h1;        corners[4] = 32'h7FFFFFFF; corners[5] = 32'hFFFFFFFE;

    rst = 1'b1; start = 1'b0; op = '0; oprd1 = '0; oprd2 = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    check("rst_hi", 64'(hi_o), 64'(0));
    check("rst_lo", 64'(lo_o), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stall", 64'(stallreq_from_ex), 64'(0));
    check("rst_done", 64'(done), 64'(0));

    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    check("multu_max_hi", 64'(hi_o), 64'h00000000FFFFFFFE);
    check("multu_max_lo", 64'(lo_o), 64'h0000000000000001);
    do_op(2'd0, 32'hFFFFFFFD, 32'd5, -1, 1'b0);
    check("mult_neg_lo", 64'(lo_o), 64'h00000000FFFFFFF1);
    do_op(2'd0, 32'h80000000, 32'h80000000, -1, 1'b0);
    check("mult_min_hi", 64'(hi_o), 64'h0000000040000000);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    check("div_neg_lo", 64'(lo_o), 64'h00000000FFFFFFFD);
    check("div_neg_hi", 64'(hi_o), 64'h00000000FFFFFFFF);
    do_op(2'd3, 32'd100, 32'd7, -1, 1'b0);
    check("divu_lo", 64'(lo_o), 64'h000000000000000E);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    check("div_ovf_lo", 64'(lo_o), 64'h0000000080000000);
    check("div_ovf_hi", 64'(hi_o), 64'h0000000000000000);

    mt_write(1'b1, 32'h11111111);
    mt_write(1'b0, 32'h22222222);
    do_op(2'd3, 32'd1234, 32'd0, -1, 1'b0);
    check("div0_hi", 64'(hi_o), 64'h0000000011111111);

    do_op(2'd1, 32'd7, 32'd9, 10, 1'b0);
    do_op(2'd1, 32'd7, 32'd9, -1, 1'b0);
    check("after_flush_lo", 64'(lo_o), 64'd63);

    do_op(2'd1, 32'd2, 32'd3, -1, 1'b1);
    check("mthi_drop_hi", 64'(hi_o), 64'd0);
    check("mthi_drop_lo", 64'(lo_o), 64'd6);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      rfl = -1; rmt = 1'b0;
      if (!(ro[1] && rb == 0)) begin
        if ($urandom_range(0, 5) == 0) rfl = int'($urandom_range(1, 32));
        else rmt = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 4) == 0) mt_write($urandom_range(0, 1) == 1, $urandom);
      do_op(ro, ra, rb, rfl, rmt);
    end

    mt_write(1'b1, 32'h5A5A5A5A);
    mt_write(1'b0, 32'hA5A5A5A5);
    for (int k = 0; k <= 20; k++) begin
      tick();
      start = 1'b1; op = 2'd3; oprd1 = 32'd1000; oprd2 = 32'd3;
      rst = (k == 20);
      #1;
    end
    tick(); rst = 1'b0; #1;
    hi_m = '0; lo_m = '0;
    check("midop_rst_hi", 64'(hi_o), 64'(hi_m));
    check("midop_rst_lo", 64'(lo_o), 64'(lo_m));
    check("midop_rst_busy", 64'(busy), 64'(0));
    check("midop_rst_done", 64'(done), 64'(0));

    do_op(2'd0, 32'hFFFFFFF0, 32'h00000010, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
